// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic             branchD;
    logic             jumpD;
    logic             regwriteE;
    logic             memtoregE;
    logic             regwriteM;
    logic             memtoregM;
    logic             regwriteW;
    logic [REG_W-1:0] rsD;
    logic [REG_W-1:0] rtD;
    logic [REG_W-1:0] rsE;
    logic [REG_W-1:0] rtE;
    logic [REG_W-1:0] writeregE;
    logic [REG_W-1:0] writeregM;
    logic [REG_W-1:0] writeregW;
    logic             mdopD;
    logic             hiloreadD;
    logic             mdstartE;
    logic             mdisdivE;
    logic             stallF;
    logic             stallD;
    logic             flushE;
    logic             forwardAD;
    logic             forwardBD;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             md_busy;
    logic             md_done;

    modport master (
        output branchD, jumpD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW,
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output mdopD, hiloreadD, mdstartE, mdisdivE,
        input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
        input  md_busy, md_done
    );

    modport slave (
        input  branchD, jumpD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW,
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  mdopD, hiloreadD, mdstartE, mdisdivE,
        output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
        output md_busy, md_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush generation and mul/div occupancy tracking
module hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam int               CNT_W   = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REG_W-1:0] R0      = '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             md_busy;
    logic             md_done;

    logic [1:0] fwd_ae;
    logic [1:0] fwd_be;
    logic       fwd_ad;
    logic       fwd_bd;
    logic       lwstall;
    logic       branchstall;
    logic       mdstall;
    logic       stall;

    // Memory-stage result is newer than Writeback, so it wins when both match.
    always_comb begin
        fwd_ae = 2'b00;
        if (hz.rsE != R0 && hz.rsE == hz.writeregM && hz.regwriteM)
            fwd_ae = 2'b10;
        else if (hz.rsE != R0 && hz.rsE == hz.writeregW && hz.regwriteW)
            fwd_ae = 2'b01;

        fwd_be = 2'b00;
        if (hz.rtE != R0 && hz.rtE == hz.writeregM && hz.regwriteM)
            fwd_be = 2'b10;
        else if (hz.rtE != R0 && hz.rtE == hz.writeregW && hz.regwriteW)
            fwd_be = 2'b01;
    end

    always_comb begin
        fwd_ad = (hz.rsD != R0) && (hz.rsD == hz.writeregM) && hz.regwriteM;
        fwd_bd = (hz.rtD != R0) && (hz.rtD == hz.writeregM) && hz.regwriteM;
    end

    // A branch resolves in Decode, so it must wait for any producer still in
    // Execute, and for a load still in Memory whose data is not yet available.
    always_comb begin
        lwstall = hz.memtoregE && (hz.rtE != R0) &&
                  ((hz.rsD == hz.rtE) || (hz.rtD == hz.rtE));

        branchstall = hz.branchD &&
            ((hz.regwriteE && (hz.writeregE != R0) &&
              ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
             (hz.memtoregM && (hz.writeregM != R0) &&
              ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));

        mdstall = md_busy && (hz.mdopD || hz.hiloreadD);
        stall   = lwstall | branchstall | mdstall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start request while BUSY is deliberately dropped: the unit is occupied.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (hz.mdstartE) begin
                    state_nxt = BUSY;
                    cnt_nxt   = hz.mdisdivE ? DIV_CNT : MUL_CNT;
                end
            end
            BUSY: begin
                if (cnt <= CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy = (state == BUSY);
        md_done = (state == BUSY) && (cnt == CNT_ONE);
    end

    // Reset holds fetch/decode free-running and keeps Execute flushed.
    assign hz.stallF    = reset ? 1'b0 : stall;
    assign hz.stallD    = reset ? 1'b0 : stall;
    assign hz.flushE    = reset | stall;
    assign hz.forwardAE = fwd_ae;
    assign hz.forwardBE = fwd_be;
    assign hz.forwardAD = fwd_ad;
    assign hz.forwardBD = fwd_bd;
    assign hz.md_busy   = md_busy;
    assign hz.md_done   = md_done;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven and sequence checks for hazard_ctrl
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5)) hz ();

    hazard_ctrl #(.REG_W(5), .MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        string      name;
        logic       br, jp, rwe, mte, rwm, mtm, rww;
        logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
        logic       stall, fad, fbd;
        logic [1:0] fae, fbe;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.branchD = 0; hz.jumpD = 0; hz.regwriteE = 0; hz.memtoregE = 0;
        hz.regwriteM = 0; hz.memtoregM = 0; hz.regwriteW = 0;
        hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
        hz.writeregE = 0; hz.writeregM = 0; hz.writeregW = 0;
        hz.mdopD = 0; hz.hiloreadD = 0; hz.mdstartE = 0; hz.mdisdivE = 0;
    endtask

    task automatic chk_stall(input string nm, input logic exp);
        chk($sformatf("%s_stallF", nm), 32'(hz.stallF), 32'(exp));
        chk($sformatf("%s_stallD", nm), 32'(hz.stallD), 32'(exp));
        chk($sformatf("%s_flushE", nm), 32'(hz.flushE), 32'(exp));
    endtask

    task automatic md_run(input string nm, input logic isdiv, input int lat, input int poke_at);
        @(negedge clk);
        hz.hiloreadD = 1'b1;
        hz.mdstartE  = 1'b1;
        hz.mdisdivE  = isdiv;
        #1;
        chk($sformatf("%s_pre_busy", nm), 32'(hz.md_busy), 32'd0);
        chk_stall($sformatf("%s_pre", nm), 1'b0);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            hz.mdstartE = (i == poke_at);
            if (i == poke_at) hz.mdisdivE = 1'b1;
            #1;
            chk($sformatf("%s_busy%0d", nm, i), 32'(hz.md_busy), 32'd1);
            chk($sformatf("%s_done%0d", nm, i), 32'(hz.md_done), 32'(i == lat));
            chk_stall($sformatf("%s_c%0d", nm, i), 1'b1);
        end
        @(negedge clk);
        hz.mdstartE = 1'b0;
        hz.mdisdivE = 1'b0;
        #1;
        chk($sformatf("%s_post_busy", nm), 32'(hz.md_busy), 32'd0);
        chk($sformatf("%s_post_done", nm), 32'(hz.md_done), 32'd0);
        chk_stall($sformatf("%s_post", nm), 1'b0);
        hz.hiloreadD = 1'b0;
    endtask

    initial begin
        //        name       br    jp    rwE   mtE   rwM   mtM   rwW   rsD    rtD    rsE    rtE    wrE    wrM     wrW    stl   fAD   fBD   fAE    fBE
        tv[0]  = '{"fwdE_m",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  5'd0,  5'd3,  5'd0,  5'd0,  5'd3,   5'd3,  1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
        tv[1]  = '{"fwdE_w",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd3,  5'd0,  5'd0,  5'd3,   5'd3,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
        tv[2]  = '{"fwdE_r0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd3,   5'd3,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[3]  = '{"lw_rs",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  5'd0,  5'd0,  5'd5,  5'd0,  5'd0,   5'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[4]  = '{"lw_zero", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,   5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[5]  = '{"br_mem",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd7,  5'd0,  5'd0,  5'd0,  5'd7,   5'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[6]  = '{"br_fwd",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd7,  5'd0,  5'd0,  5'd0,  5'd7,   5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
        tv[7]  = '{"br_ex",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  5'd0,  5'd0,  5'd0,  5'd4,  5'd0,   5'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[8]  = '{"br_ex0",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,   5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[9]  = '{"jump",    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  5'd0,  5'd0,  5'd0,  5'd4,  5'd0,   5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[10] = '{"fwdBE_w", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  5'd9,  5'd0,  5'd0,   5'd9,  1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
        tv[11] = '{"lw_rt",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2,  5'd6,  5'd0,  5'd6,  5'd0,  5'd0,   5'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        tv[12] = '{"fwdAD",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 5'd0,  5'd0,  5'd0,  5'd0,  5'd12,  5'd0,  1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
        tv[13] = '{"fwdAD_r0",1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,   5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

        // Reset: stall inputs active, yet stalls must be masked and Execute flushed.
        clear_inputs();
        hz.memtoregE = 1'b1; hz.rtE = 5'd5; hz.rsD = 5'd5;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(hz.md_busy), 32'd0);
        chk("rst_done", 32'(hz.md_done), 32'd0);
        chk("rst_stallF", 32'(hz.stallF), 32'd0);
        chk("rst_stallD", 32'(hz.stallD), 32'd0);
        chk("rst_flushE", 32'(hz.flushE), 32'd1);
        reset = 1'b0;
        clear_inputs();

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            hz.branchD = tv[k].br;    hz.jumpD = tv[k].jp;
            hz.regwriteE = tv[k].rwe; hz.memtoregE = tv[k].mte;
            hz.regwriteM = tv[k].rwm; hz.memtoregM = tv[k].mtm;
            hz.regwriteW = tv[k].rww;
            hz.rsD = tv[k].rsd; hz.rtD = tv[k].rtd; hz.rsE = tv[k].rse; hz.rtE = tv[k].rte;
            hz.writeregE = tv[k].wre; hz.writeregM = tv[k].wrm; hz.writeregW = tv[k].wrw;
            #1;
            chk_stall(tv[k].name, tv[k].stall);
            chk($sformatf("%s_fAD", tv[k].name), 32'(hz.forwardAD), 32'(tv[k].fad));
            chk($sformatf("%s_fBD", tv[k].name), 32'(hz.forwardBD), 32'(tv[k].fbd));
            chk($sformatf("%s_fAE", tv[k].name), 32'(hz.forwardAE), 32'(tv[k].fae));
            chk($sformatf("%s_fBE", tv[k].name), 32'(hz.forwardBE), 32'(tv[k].fbe));
        end
        @(negedge clk);
        clear_inputs();

        md_run("mul", 1'b0, 4, 0);
        md_run("mul_poke", 1'b0, 4, 2);

        // Load-use and mul/div stall together, forwarding unaffected.
        @(negedge clk);
        hz.mdstartE = 1'b1; hz.mdisdivE = 1'b0;
        @(negedge clk);
        hz.mdstartE = 1'b0; hz.mdopD = 1'b1;
        hz.memtoregE = 1'b1; hz.rtE = 5'd5; hz.rsD = 5'd5;
        hz.rsE = 5'd3; hz.writeregM = 5'd3; hz.regwriteM = 1'b1;
        #1;
        chk_stall("combo", 1'b1);
        chk("combo_fAE", 32'(hz.forwardAE), 32'd2);
        chk("combo_fAD", 32'(hz.forwardAD), 32'd0);
        repeat (4) @(negedge clk);
        clear_inputs();
        #1;
        chk("combo_idle", 32'(hz.md_busy), 32'd0);

        // Divide aborted by reset at busy cycle 10.
        @(negedge clk);
        hz.mdstartE = 1'b1; hz.mdisdivE = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            hz.mdstartE = 1'b0; hz.mdisdivE = 1'b0;
            #1;
            chk($sformatf("div_busy%0d", i), 32'(hz.md_busy), 32'd1);
            chk($sformatf("div_done%0d", i), 32'(hz.md_done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_busy", 32'(hz.md_busy), 32'd0);
        chk("abort_done", 32'(hz.md_done), 32'd0);
        reset = 1'b0;
        hz.mdstartE = 1'b1; hz.mdisdivE = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            hz.mdstartE = 1'b0;
            #1;
            chk($sformatf("restart_busy%0d", i), 32'(hz.md_busy), 32'd1);
            chk($sformatf("restart_done%0d", i), 32'(hz.md_done), 32'(i == 4));
        end
        @(negedge clk);
        #1;
        chk("restart_idle", 32'(hz.md_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
